serial_subtractor_4bit: RTL and testbench

SERIAL_SUBTRACTOR_4BIT -- requirements
Module: serial_subtractor_4bit

---
 rtl/serial_subtractor_4bit_pkg.sv | 17 +
 rtl/serial_subtractor_4bit_full_subtractor.sv | 18 +
 rtl/serial_subtractor_4bit.sv | 115 +++++++++++
 tb/tb_serial_subtractor_4bit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_4bit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_subtractor_4bit_pkg : shared width default and FSM state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
package serial_subtractor_4bit_pkg;

   localparam int WIDTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage : serial_subtractor_4bit_pkg
`default_nettype wire

// File: rtl/serial_subtractor_4bit_full_subtractor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// full_subtractor : one-bit a - b - bin with borrow-out
// Rev 1.0
// ----------------------------------------------------------------------------
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor_4bit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_subtractor_4bit : bit-serial Diff = A - B - Bin, one bit per cycle
// Rev 1.0
// ----------------------------------------------------------------------------
module serial_subtractor_4bit
   import serial_subtractor_4bit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] C_LAST_BIT = CW'(WIDTH - 1);

   state_e           state_q,   state_d;
   logic [WIDTH-1:0] a_sr_q,    a_sr_d;
   logic [WIDTH-1:0] b_sr_q,    b_sr_d;
   logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
   logic             borrow_q,  borrow_d;
   logic [CW-1:0]    cnt_q,     cnt_d;
   logic [WIDTH-1:0] diff_q,    diff_d;
   logic             bout_q,    bout_d;

   logic             w_diff_bit;
   logic             w_borrow_out;

   full_subtractor u_full_subtractor (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .bin  (borrow_q),
      .d    (w_diff_bit),
      .bout (w_borrow_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         a_sr_q    <= '0;
         b_sr_q    <= '0;
         diff_sr_q <= '0;
         borrow_q  <= 1'b0;
         cnt_q     <= '0;
         diff_q    <= '0;
         bout_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_sr_q    <= a_sr_d;
         b_sr_q    <= b_sr_d;
         diff_sr_q <= diff_sr_d;
         borrow_q  <= borrow_d;
         cnt_q     <= cnt_d;
         diff_q    <= diff_d;
         bout_q    <= bout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_sr_d    = a_sr_q;
      b_sr_d    = b_sr_q;
      diff_sr_d = diff_sr_q;
      borrow_d  = borrow_q;
      cnt_d     = cnt_q;
      diff_d    = diff_q;
      bout_d    = bout_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_sr_d   = A;
               b_sr_d   = B;
               borrow_d = Bin;
               cnt_d    = '0;
               state_d  = SHIFT;
            end else begin
               state_d  = IDLE;
            end
         end
         SHIFT: begin
            // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
            a_sr_d    = a_sr_q >> 1;
            b_sr_d    = b_sr_q >> 1;
            diff_sr_d = {w_diff_bit, diff_sr_q[WIDTH-1:1]};
            borrow_d  = w_borrow_out;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == C_LAST_BIT) begin
               diff_d  = {w_diff_bit, diff_sr_q[WIDTH-1:1]};
               bout_d  = w_borrow_out;
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign Diff = diff_q;
   assign Bout = bout_q;

endmodule : serial_subtractor_4bit
`default_nettype wire

// File: tb/tb_serial_subtractor_4bit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_serial_subtractor_4bit : directed vectors plus a timeline model of A-B-Bin
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_serial_subtractor_4bit;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] A;
   logic [3:0] B;
   logic       Bin;
   logic       busy;
   logic       done;
   logic [3:0] Diff;
   logic       Bout;

   int n_cmp = 0;
   int n_err = 0;

   serial_subtractor_4bit #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Bin   (Bin),
      .busy  (busy),
      .done  (done),
      .Diff  (Diff),
      .Bout  (Bout)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: an operation accepted at edge s is busy after edges s..s+3,
   // shows done after edge s+4 and publishes its result on that edge.
   int         edge_n  = 0;
   int         m_acc   = 0;
   bit         m_valid = 1'b0;
   logic [3:0] m_diff  = '0, p_diff = '0;
   logic       m_bout  = 1'b0, p_bout = 1'b0;
   logic       exp_busy = 1'b0, exp_done = 1'b0;
   bit         chk_en  = 1'b0;

   always @(posedge clk) begin
      edge_n++;
      if (rst) begin
         m_valid = 1'b0;
         m_diff  = '0;
         m_bout  = 1'b0;
      end else begin
         if (m_valid && (edge_n - m_acc == 4)) begin
            m_diff = p_diff;
            m_bout = p_bout;
         end
         if (start && !(m_valid && (edge_n - 1 - m_acc) >= 0 && (edge_n - 1 - m_acc) <= 3)) begin
            m_valid = 1'b1;
            m_acc   = edge_n;
            p_diff  = 4'(int'(A) - int'(B) - int'(Bin));
            p_bout  = (int'(A) < int'(B) + int'(Bin));
         end
      end
      exp_busy = m_valid && (edge_n - m_acc >= 0) && (edge_n - m_acc <= 3);
      exp_done = m_valid && (edge_n - m_acc == 4);
      chk_en   = 1'b1;
   end

   int done_cnt = 0;
   int done_edges[$];

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc busy", 32'(busy), 32'(exp_busy));
         check("cyc done", 32'(done), 32'(exp_done));
         check("cyc Diff", 32'(Diff), 32'(m_diff));
         check("cyc Bout", 32'(Bout), 32'(m_bout));
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_edges.push_back(edge_n);
      end
   end

   // Entered and left at 1 time unit after a rising edge.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                         input logic [3:0] ed, input logic eb, input string tag);
      int n;
      bit seen;
      A = a; B = b; Bin = bi; start = 1'b1;
      n = 0; seen = 1'b0;
      while (!seen && n < 12) begin
         @(posedge clk);
         n++;
         #1;
         if (n == 1) begin
            start = 1'b0;
            A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom);
         end
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      check({tag, " latency"}, 32'(n), 32'd5);
      check({tag, " Diff"}, 32'(Diff), 32'(ed));
      check({tag, " Bout"}, 32'(Bout), 32'(eb));
      check({tag, " model Diff"}, 32'(m_diff), 32'(ed));
      check({tag, " model Bout"}, 32'(m_bout), 32'(eb));
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset Diff", 32'(Diff), 32'd0);
      check("reset Bout", 32'(Bout), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, "v1");
      run_op(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, "v2");
      run_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, "v3");
      run_op(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, "v4");
      run_op(4'b1010, 4'b0101, 1'b1, 4'b0100, 1'b0, "v5");

      // start during busy cycle 2 must be ignored
      base = done_cnt;
      A = 4'b0101; B = 4'b0011; Bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      A = 4'b0001; B = 4'b0001; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("ignore Diff", 32'(Diff), 32'b0010);
      check("ignore Bout", 32'(Bout), 32'd0);
      check("ignore done count", 32'(done_cnt - base), 32'd1);

      // reset on SHIFT cycle 3 aborts without a done pulse
      base = done_cnt;
      A = 4'b1100; B = 4'b0001; Bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("abort done count", 32'(done_cnt - base), 32'd0);
      check("abort Diff", 32'(Diff), 32'd0);
      check("abort Bout", 32'(Bout), 32'd0);
      run_op(4'b0110, 4'b0010, 1'b0, 4'b0100, 1'b0, "post-abort");

      // start held for 15 cycles: three operations, 5 cycles apart
      base = done_cnt;
      done_edges.delete();
      A = 4'b1001; B = 4'b0100; Bin = 1'b1; start = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("held done count", 32'(done_cnt - base), 32'd3);
      for (int i = 1; i < done_edges.size(); i++)
         check("held spacing", 32'(done_edges[i] - done_edges[i-1]), 32'd5);
      check("held Diff", 32'(Diff), 32'b0100);
      check("held Bout", 32'(Bout), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_serial_subtractor_4bit
`default_nettype wire
